// File: rtl/block_ram_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_hs_if
// Brief    : One request/response port of block_ram_hs (valid/ready request,
//            fixed-latency response without backpressure).
// Revision : 1.0 - initial release
// ============================================================================
interface block_ram_hs_if #(
    parameter int ABITS  = 8,
    parameter int DBYTES = 4,
    parameter int BLEN   = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic [DBYTES-1:0]         req_we;
    logic [ABITS-1:0]          req_addr;
    logic [DBYTES*BLEN-1:0]    req_wdata;
    logic                      rsp_valid;
    logic [DBYTES*BLEN-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/block_ram_hs.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_hs
// Brief    : True dual-port byte-writable RAM with valid/ready requests,
//            read-first fixed-latency responses and optional zero-clear.
// Revision : 1.0 - initial release
// ============================================================================
module block_ram_hs #(
    parameter int ABITS          = 8,
    parameter int DBYTES         = 4,
    parameter int BLEN           = 8,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    output logic               init_busy,
    block_ram_hs_if.slave      a,
    block_ram_hs_if.slave      b
);

    localparam int              c_DBITS    = DBYTES * BLEN;
    localparam int              c_DEPTH    = 1 << ABITS;
    localparam logic [ABITS:0]  c_CLR_LAST = (ABITS+1)'(c_DEPTH - 1);
    localparam logic [ABITS:0]  c_CLR_ONE  = (ABITS+1)'(1);
    localparam logic [0:0]      c_CLEAR    = 1'b0;
    localparam logic [0:0]      c_READY    = 1'b1;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("block_ram_hs: LATENCY must be in 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear sweep FSM
    // ------------------------------------------------------------------
    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [ABITS:0] r_clr_cnt;
    logic [ABITS:0] w_clr_cnt_nxt;
    logic           w_clr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? c_CLEAR : c_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            c_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + c_CLR_ONE;
                if (r_clr_cnt == c_CLR_LAST) begin
                    w_state_nxt = c_READY;
                end
            end
            default: begin
                w_state_nxt = c_READY;
            end
        endcase
    end

    assign init_busy = (r_state == c_CLEAR);
    // Array writes are gated by rst_n so nothing lands while reset is held.
    assign w_clr_we  = init_busy & rst_n;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic              w_acc   [2];
    logic [DBYTES-1:0] w_we    [2];
    logic [ABITS-1:0]  w_addr  [2];
    logic [c_DBITS-1:0] w_wdata [2];
    logic [c_DBITS-1:0] w_rd    [2];
    logic              w_rsp_valid [2];
    logic [c_DBITS-1:0] w_rsp_rdata [2];

    assign a.req_ready = ~init_busy;
    assign b.req_ready = ~init_busy;

    assign w_acc[0]   = a.req_valid & ~init_busy & rst_n;
    assign w_acc[1]   = b.req_valid & ~init_busy & rst_n;
    assign w_we[0]    = a.req_we;
    assign w_we[1]    = b.req_we;
    assign w_addr[0]  = a.req_addr;
    assign w_addr[1]  = b.req_addr;
    assign w_wdata[0] = a.req_wdata;
    assign w_wdata[1] = b.req_wdata;

    // ------------------------------------------------------------------
    // Storage: one array per byte lane. Port A's assignment comes last so
    // it wins any byte both ports enable on the same word.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DBYTES; i++) begin : g_lane
            logic [BLEN-1:0] r_mem [c_DEPTH];

            always_ff @(posedge clk) begin
                if (w_clr_we) begin
                    r_mem[r_clr_cnt[ABITS-1:0]] <= '0;
                end else begin
                    if (w_acc[1] && w_we[1][i]) begin
                        r_mem[w_addr[1]] <= w_wdata[1][i*BLEN +: BLEN];
                    end
                    if (w_acc[0] && w_we[0][i]) begin
                        r_mem[w_addr[0]] <= w_wdata[0][i*BLEN +: BLEN];
                    end
                end
            end

            assign w_rd[0][i*BLEN +: BLEN] = r_mem[w_addr[0]];
            assign w_rd[1][i*BLEN +: BLEN] = r_mem[w_addr[1]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response pipeline: stage 0 registers the pre-write word, later stages
    // only load when their predecessor is valid so rdata holds when idle.
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [LATENCY-1:0]              r_v;
            logic [LATENCY-1:0][c_DBITS-1:0] r_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                    r_d <= '0;
                end else begin
                    r_v[0] <= w_acc[p];
                    if (w_acc[p]) begin
                        r_d[0] <= w_rd[p];
                    end
                    for (int k = 1; k < LATENCY; k++) begin
                        r_v[k] <= r_v[k-1];
                        if (r_v[k-1]) begin
                            r_d[k] <= r_d[k-1];
                        end
                    end
                end
            end

            assign w_rsp_valid[p] = r_v[LATENCY-1];
            assign w_rsp_rdata[p] = r_d[LATENCY-1];
        end
    endgenerate

    assign a.rsp_valid = w_rsp_valid[0];
    assign a.rsp_rdata = w_rsp_rdata[0];
    assign b.rsp_valid = w_rsp_valid[1];
    assign b.rsp_rdata = w_rsp_rdata[1];

endmodule
`default_nettype wire
